// File: rtl/spu_dispatch_if.sv
// spu_dispatch_if -- host-side control bundle of the SPU dispatcher.
//
// Handshake: the host raises spu_config_en / spu_start / spu_err_clr for one
// core_clk cycle each; they are sampled on the rising edge and need no ready.
// spu_end is a one-cycle completion/abort pulse; spu_busy is a level that is
// high while a job is in flight. No back-pressure exists on any signal.
//
// Signals:
//   spu_config_en, spu_op_in, spu_cfg_in : write the pending job slot
//   spu_start                            : launch pulse
//   spu_err_clr                          : clear the sticky error
//   timeout_limit                        : max RUN cycles (0 disables)
//   spu_end, spu_busy                    : job status
//   spu_err, spu_err_code                : sticky first error and its code
//   spu_cycles                           : LAUNCH+RUN cycles of the last job
// Modports: master = host side, slave = dispatcher side.
interface spu_dispatch_if #(
    parameter int OP_W  = 4,
    parameter int CFG_W = 96,
    parameter int TO_W  = 16
);
    logic             spu_config_en;
    logic [OP_W-1:0]  spu_op_in;
    logic [CFG_W-1:0] spu_cfg_in;
    logic             spu_start;
    logic             spu_err_clr;
    logic [TO_W-1:0]  timeout_limit;
    logic             spu_end;
    logic             spu_busy;
    logic             spu_err;
    logic [2:0]       spu_err_code;
    logic [31:0]      spu_cycles;

    modport master (
        output spu_config_en, spu_op_in, spu_cfg_in, spu_start, spu_err_clr,
               timeout_limit,
        input  spu_end, spu_busy, spu_err, spu_err_code, spu_cycles
    );

    modport slave (
        input  spu_config_en, spu_op_in, spu_cfg_in, spu_start, spu_err_clr,
               timeout_limit,
        output spu_end, spu_busy, spu_err, spu_err_code, spu_cycles
    );
endinterface

// File: rtl/spu_dispatch.sv
// spu_dispatch -- launches jobs on one of NUM_OPS attached sub-units and
// owns the shared lbuf port while the selected unit runs.
//
// Ports:
//   core_clk, rst       : clock, synchronous active-high reset
//   host                : spu_dispatch_if.slave control/status bundle
//   sub_start/sub_end   : per-unit one-hot start pulse / end strobe
//   sub_cfg             : config word of the active job
//   sub_lbuf_*          : per-unit lbuf requests, unit i in slice i
//   lbuf_*              : shared lbuf port, driven by the active unit in RUN
//   dbg_state           : FSM state (IDLE=0, LAUNCH=1, RUN=2, DONE=3)
module spu_dispatch #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OPS    = 4,
    parameter int OP_W       = 4,
    parameter int CFG_W      = 96,
    parameter int TO_W       = 16
) (
    input  logic                           core_clk,
    input  logic                           rst,
    spu_dispatch_if.slave                  host,
    output logic [NUM_OPS-1:0]             sub_start,
    input  logic [NUM_OPS-1:0]             sub_end,
    output logic [CFG_W-1:0]               sub_cfg,
    input  logic [NUM_OPS-1:0]             sub_lbuf_ren,
    input  logic [NUM_OPS-1:0]             sub_lbuf_wen,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0]  sub_lbuf_raddr,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0]  sub_lbuf_waddr,
    input  logic [NUM_OPS*DATA_WIDTH-1:0]  sub_lbuf_wdata,
    output logic                           lbuf_ren,
    output logic                           lbuf_wen,
    output logic [ADDR_WIDTH-1:0]          lbuf_raddr,
    output logic [ADDR_WIDTH-1:0]          lbuf_waddr,
    output logic [DATA_WIDTH-1:0]          lbuf_wdata,
    output logic [1:0]                     dbg_state
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [2:0] ERR_NO_CFG    = 3'd1;
    localparam logic [2:0] ERR_BAD_OP    = 3'd2;
    localparam logic [2:0] ERR_START_OVF = 3'd3;
    localparam logic [2:0] ERR_CFG_OVF   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd5;

    localparam logic [OP_W:0] NUM_OPS_C = (OP_W+1)'(NUM_OPS);

    logic [1:0]       state_q, state_d;
    logic [OP_W-1:0]  act_op_q, act_op_d;
    logic [CFG_W-1:0] act_cfg_q, act_cfg_d;
    logic             pend_valid_q, pend_valid_d;
    logic [OP_W-1:0]  pend_op_q, pend_op_d;
    logic [CFG_W-1:0] pend_cfg_q, pend_cfg_d;
    logic             start_q_q, start_q_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [TO_W-1:0]  run_cnt_q, run_cnt_d;
    logic [31:0]      cycles_q, cycles_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;

    logic             busy;
    logic             pend_op_ok;
    logic             start_busy_ok;
    logic             sel_end;
    logic [TO_W:0]    run_next;
    logic             new_err;
    logic [2:0]       new_code;

    assign busy          = (state_q != ST_IDLE);
    assign pend_op_ok    = ({1'b0, pend_op_q} < NUM_OPS_C);
    // A start while busy can only be queued behind a held config.
    assign start_busy_ok = pend_valid_q && !start_q_q;
    assign run_next      = {1'b0, run_cnt_q} + {{TO_W{1'b0}}, 1'b1};

    // Per-unit selection by the active op: end strobe, start pulse, lbuf mux.
    always_comb begin
        sel_end    = 1'b0;
        sub_start  = '0;
        lbuf_ren   = 1'b0;
        lbuf_wen   = 1'b0;
        lbuf_raddr = '0;
        lbuf_waddr = '0;
        lbuf_wdata = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (act_op_q == OP_W'(i)) begin
                sel_end      = sub_end[i];
                sub_start[i] = (state_q == ST_LAUNCH);
                lbuf_ren     = sub_lbuf_ren[i] && (state_q == ST_RUN);
                lbuf_wen     = sub_lbuf_wen[i] && (state_q == ST_RUN);
                lbuf_raddr   = sub_lbuf_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                lbuf_waddr   = sub_lbuf_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                lbuf_wdata   = sub_lbuf_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        act_op_d     = act_op_q;
        act_cfg_d    = act_cfg_q;
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_cfg_d   = pend_cfg_q;
        start_q_d    = start_q_q;
        cnt_d        = cnt_q;
        run_cnt_d    = run_cnt_q;
        cycles_d     = cycles_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        new_err      = 1'b0;
        new_code     = 3'd0;

        if (host.spu_start && busy) begin
            if (start_busy_ok) begin
                start_q_d = 1'b1;
            end else begin
                new_err  = 1'b1;
                new_code = ERR_START_OVF;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (host.spu_start) begin
                    if (!pend_valid_q) begin
                        new_err  = 1'b1;
                        new_code = ERR_NO_CFG;
                    end else if (!pend_op_ok) begin
                        pend_valid_d = 1'b0;
                        new_err      = 1'b1;
                        new_code     = ERR_BAD_OP;
                    end else begin
                        act_op_d     = pend_op_q;
                        act_cfg_d    = pend_cfg_q;
                        pend_valid_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d     = cnt_q + 32'd1;
                run_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cnt_d     = cnt_q + 32'd1;
                run_cnt_d = run_next[TO_W-1:0];
                // The end strobe is checked first so it wins in the limit cycle.
                if (sel_end) begin
                    cycles_d = cnt_q + 32'd1;
                    state_d  = ST_DONE;
                end else if ((host.timeout_limit != '0) &&
                             (run_next == {1'b0, host.timeout_limit})) begin
                    cycles_d = cnt_q + 32'd1;
                    state_d  = ST_DONE;
                    new_err  = 1'b1;
                    new_code = ERR_TIMEOUT;
                end
            end
            default: begin // ST_DONE
                start_q_d = 1'b0;
                // A start arriving in DONE itself chains just like a queued one.
                if (start_q_q || (host.spu_start && start_busy_ok)) begin
                    pend_valid_d = 1'b0;
                    if (pend_op_ok) begin
                        act_op_d  = pend_op_q;
                        act_cfg_d = pend_cfg_q;
                        cnt_d     = '0;
                        state_d   = ST_LAUNCH;
                    end else begin
                        new_err  = 1'b1;
                        new_code = ERR_BAD_OP;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Config writes land after any start consumed the old pending slot.
        if (host.spu_config_en) begin
            if (busy && pend_valid_q) begin
                new_err  = 1'b1;
                new_code = ERR_CFG_OVF;
            end else begin
                pend_valid_d = 1'b1;
                pend_op_d    = host.spu_op_in;
                pend_cfg_d   = host.spu_cfg_in;
            end
        end

        if (host.spu_err_clr) begin
            err_d      = 1'b0;
            err_code_d = 3'd0;
        end
        if (new_err && (!err_q || host.spu_err_clr)) begin
            err_d      = 1'b1;
            err_code_d = new_code;
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            act_op_q     <= '0;
            act_cfg_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_op_q    <= '0;
            pend_cfg_q   <= '0;
            start_q_q    <= 1'b0;
            cnt_q        <= '0;
            run_cnt_q    <= '0;
            cycles_q     <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            act_op_q     <= act_op_d;
            act_cfg_q    <= act_cfg_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_cfg_q   <= pend_cfg_d;
            start_q_q    <= start_q_d;
            cnt_q        <= cnt_d;
            run_cnt_q    <= run_cnt_d;
            cycles_q     <= cycles_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign sub_cfg           = act_cfg_q;
    assign host.spu_end      = (state_q == ST_DONE);
    assign host.spu_busy     = busy;
    assign host.spu_err      = err_q;
    assign host.spu_err_code = err_code_q;
    assign host.spu_cycles   = cycles_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_spu_dispatch.sv
module tb_spu_dispatch;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NO = 4;

    logic             clk;
    logic             rst;
    logic [NO-1:0]    sub_start;
    logic [NO-1:0]    sub_end;
    logic [95:0]      sub_cfg;
    logic [NO-1:0]    sub_lbuf_ren;
    logic [NO-1:0]    sub_lbuf_wen;
    logic [NO*AW-1:0] sub_lbuf_raddr;
    logic [NO*AW-1:0] sub_lbuf_waddr;
    logic [NO*DW-1:0] sub_lbuf_wdata;
    logic             lbuf_ren;
    logic             lbuf_wen;
    logic [AW-1:0]    lbuf_raddr;
    logic [AW-1:0]    lbuf_waddr;
    logic [DW-1:0]    lbuf_wdata;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [95:0] CFG_X = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    localparam logic [95:0] CFG_A = 96'hAAAA_0000_1111_2222_3333_4444;
    localparam logic [95:0] CFG_B = 96'hBBBB_5555_6666_7777_8888_9999;
    localparam logic [95:0] CFG_C1 = 96'h0000_0000_0000_0000_0000_00C1;
    localparam logic [95:0] CFG_C2 = 96'h0000_0000_0000_0000_0000_00C2;
    localparam logic [95:0] CFG_C3 = 96'h0000_0000_0000_0000_0000_00C3;

    spu_dispatch_if #(.OP_W(4), .CFG_W(96), .TO_W(16)) hif ();

    spu_dispatch #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OPS(NO),
        .OP_W(4), .CFG_W(96), .TO_W(16)
    ) dut (
        .core_clk       (clk),
        .rst            (rst),
        .host           (hif.slave),
        .sub_start      (sub_start),
        .sub_end        (sub_end),
        .sub_cfg        (sub_cfg),
        .sub_lbuf_ren   (sub_lbuf_ren),
        .sub_lbuf_wen   (sub_lbuf_wen),
        .sub_lbuf_raddr (sub_lbuf_raddr),
        .sub_lbuf_waddr (sub_lbuf_waddr),
        .sub_lbuf_wdata (sub_lbuf_wdata),
        .lbuf_ren       (lbuf_ren),
        .lbuf_wen       (lbuf_wen),
        .lbuf_raddr     (lbuf_raddr),
        .lbuf_waddr     (lbuf_waddr),
        .lbuf_wdata     (lbuf_wdata),
        .dbg_state      (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_config(input logic [3:0] op, input logic [95:0] cfg);
        hif.spu_config_en = 1'b1;
        hif.spu_op_in     = op;
        hif.spu_cfg_in    = cfg;
        tick();
        hif.spu_config_en = 1'b0;
    endtask

    task automatic drive_start();
        hif.spu_start = 1'b1;
        tick();
        hif.spu_start = 1'b0;
    endtask

    task automatic drive_clr();
        hif.spu_err_clr = 1'b1;
        tick();
        hif.spu_err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (hif.spu_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b want 0", hif.spu_busy);
        end
        checks++;
        if ({hif.spu_err, hif.spu_err_code} !== 4'd0) begin
            errors++; $display("FAIL reset_err: got %0b/%0d want 0/0", hif.spu_err, hif.spu_err_code);
        end
        checks++;
        if (hif.spu_cycles !== 32'd0 || sub_cfg !== 96'd0 || sub_start !== 4'd0) begin
            errors++; $display("FAIL reset_outputs: cycles %0d cfg %h start %b want 0", hif.spu_cycles, sub_cfg, sub_start);
        end
    endtask

    task automatic test_basic();
        drive_config(4'd1, CFG_X);
        drive_start();
        // c1: LAUNCH
        checks++;
        if (sub_start !== 4'b0010 || dbg_state !== 2'd1) begin
            errors++; $display("FAIL basic_launch: sub_start %b state %0d want 0010/1", sub_start, dbg_state);
        end
        tick(); // c2: RUN
        checks++;
        if (sub_start !== 4'b0000 || sub_cfg !== CFG_X) begin
            errors++; $display("FAIL basic_run: sub_start %b cfg %h want 0000/%h", sub_start, sub_cfg, CFG_X);
        end
        sub_end = 4'b0001; // unselected unit must be ignored
        tick(); // c3
        sub_end = 4'b0000;
        checks++;
        if (dbg_state !== 2'd2 || hif.spu_end !== 1'b0) begin
            errors++; $display("FAIL basic_ignore_end: state %0d end %0b want 2/0", dbg_state, hif.spu_end);
        end
        for (int c = 4; c <= 10; c++) tick();
        sub_end = 4'b0010; // c10
        tick(); // c11: DONE
        sub_end = 4'b0000;
        checks++;
        if (hif.spu_end !== 1'b1 || hif.spu_cycles !== 32'd10 || sub_cfg !== CFG_X) begin
            errors++; $display("FAIL basic_done: end %0b cycles %0d cfg %h want 1/10/%h", hif.spu_end, hif.spu_cycles, sub_cfg, CFG_X);
        end
        tick();
        checks++;
        if (hif.spu_busy !== 1'b0 || hif.spu_end !== 1'b0 || hif.spu_err !== 1'b0) begin
            errors++; $display("FAIL basic_idle: busy %0b end %0b err %0b want 0/0/0", hif.spu_busy, hif.spu_end, hif.spu_err);
        end
    endtask

    task automatic test_back_to_back();
        drive_config(4'd2, CFG_A);
        drive_start(); // LAUNCH op 2
        checks++;
        if (sub_start !== 4'b0100) begin
            errors++; $display("FAIL b2b_launch2: sub_start %b want 0100", sub_start);
        end
        drive_config(4'd0, CFG_B); // now RUN
        drive_start();             // queued
        checks++;
        if (hif.spu_err !== 1'b0 || hif.spu_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_queue: err %0b busy %0b want 0/1", hif.spu_err, hif.spu_busy);
        end
        tick();
        sub_end = 4'b0100;
        tick(); // DONE
        sub_end = 4'b0000;
        checks++;
        if (hif.spu_end !== 1'b1 || sub_cfg !== CFG_A) begin
            errors++; $display("FAIL b2b_done: end %0b cfg %h want 1/%h", hif.spu_end, sub_cfg, CFG_A);
        end
        tick(); // LAUNCH op 0 with no IDLE gap
        checks++;
        if (sub_start !== 4'b0001 || sub_cfg !== CFG_B || hif.spu_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_launch0: start %b cfg %h busy %0b want 0001/%h/1", sub_start, sub_cfg, hif.spu_busy, CFG_B);
        end
        tick();
        sub_end = 4'b0001;
        tick();
        sub_end = 4'b0000;
        tick();
        checks++;
        if (hif.spu_busy !== 1'b0 || hif.spu_err !== 1'b0) begin
            errors++; $display("FAIL b2b_end: busy %0b err %0b want 0/0", hif.spu_busy, hif.spu_err);
        end
    endtask

    task automatic test_no_cfg();
        drive_start();
        checks++;
        if (hif.spu_err !== 1'b1 || hif.spu_err_code !== 3'd1 || sub_start !== 4'd0 || hif.spu_busy !== 1'b0) begin
            errors++; $display("FAIL no_cfg: err %0b code %0d start %b busy %0b want 1/1/0000/0", hif.spu_err, hif.spu_err_code, sub_start, hif.spu_busy);
        end
        drive_clr();
        checks++;
        if (hif.spu_err !== 1'b0 || hif.spu_err_code !== 3'd0) begin
            errors++; $display("FAIL no_cfg_clr: err %0b code %0d want 0/0", hif.spu_err, hif.spu_err_code);
        end
    endtask

    task automatic test_same_cycle_and_ovf();
        drive_config(4'd1, CFG_C1);
        // start and config together: start takes the old slot
        hif.spu_config_en = 1'b1;
        hif.spu_op_in     = 4'd2;
        hif.spu_cfg_in    = CFG_C2;
        hif.spu_start     = 1'b1;
        tick();
        hif.spu_config_en = 1'b0;
        hif.spu_start     = 1'b0;
        checks++;
        if (sub_start !== 4'b0010 || sub_cfg !== CFG_C1 || hif.spu_err !== 1'b0) begin
            errors++; $display("FAIL same_cycle: start %b cfg %h err %0b want 0010/%h/0", sub_start, sub_cfg, hif.spu_err, CFG_C1);
        end
        drive_config(4'd3, CFG_C3); // pending full while busy -> dropped
        checks++;
        if (hif.spu_err !== 1'b1 || hif.spu_err_code !== 3'd4) begin
            errors++; $display("FAIL cfg_ovf: err %0b code %0d want 1/4", hif.spu_err, hif.spu_err_code);
        end
        sub_end = 4'b0010;
        tick();
        sub_end = 4'b0000;
        tick();
        drive_start();
        checks++;
        if (sub_start !== 4'b0100 || sub_cfg !== CFG_C2) begin
            errors++; $display("FAIL cfg_ovf_kept: start %b cfg %h want 0100/%h", sub_start, sub_cfg, CFG_C2);
        end
        tick();
        sub_end = 4'b0100;
        tick();
        sub_end = 4'b0000;
        tick();
        drive_clr();
    endtask

    task automatic test_timeout();
        hif.timeout_limit = 16'd5;
        for (int pass = 0; pass < 2; pass++) begin
            drive_config(4'd0, CFG_A);
            drive_start(); // LAUNCH
            for (int r = 1; r <= 5; r++) tick(); // now in 5th RUN cycle
            checks++;
            if (dbg_state !== 2'd2 || hif.spu_end !== 1'b0) begin
                errors++; $display("FAIL timeout_r5_%0d: state %0d end %0b want 2/0", pass, dbg_state, hif.spu_end);
            end
            if (pass == 1) sub_end = 4'b0001;
            tick();
            sub_end = 4'b0000;
            checks++;
            if (pass == 0) begin
                if (hif.spu_end !== 1'b1 || hif.spu_err_code !== 3'd5 || hif.spu_cycles !== 32'd6) begin
                    errors++; $display("FAIL timeout_hit: end %0b code %0d cycles %0d want 1/5/6", hif.spu_end, hif.spu_err_code, hif.spu_cycles);
                end
            end else begin
                if (hif.spu_end !== 1'b1 || hif.spu_err !== 1'b0 || hif.spu_cycles !== 32'd6) begin
                    errors++; $display("FAIL timeout_end_wins: end %0b err %0b cycles %0d want 1/0/6", hif.spu_end, hif.spu_err, hif.spu_cycles);
                end
            end
            tick();
            drive_clr();
        end
        hif.timeout_limit = 16'd0;
    endtask

    task automatic test_bad_op();
        drive_config(4'd9, CFG_B);
        drive_start();
        checks++;
        if (hif.spu_err_code !== 3'd2 || hif.spu_busy !== 1'b0 || sub_start !== 4'd0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL bad_op: code %0d busy %0b start %b state %0d want 2/0/0000/0", hif.spu_err_code, hif.spu_busy, sub_start, dbg_state);
        end
        drive_clr();
        drive_start(); // pending was discarded -> NO_CFG
        checks++;
        if (hif.spu_err_code !== 3'd1) begin
            errors++; $display("FAIL bad_op_discard: code %0d want 1", hif.spu_err_code);
        end
        drive_clr();
    endtask

    task automatic test_lbuf_and_reset();
        sub_lbuf_waddr = {12'h333, 12'h222, 12'h111, 12'h000};
        sub_lbuf_raddr = {12'h3A3, 12'h2A2, 12'h1A1, 12'h0A0};
        sub_lbuf_wdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
        drive_config(4'd3, CFG_X);
        drive_start(); // LAUNCH
        sub_lbuf_wen = 4'b1010;
        #1;
        checks++;
        if (lbuf_wen !== 1'b0) begin
            errors++; $display("FAIL lbuf_launch_gate: wen %0b want 0", lbuf_wen);
        end
        sub_lbuf_wen = 4'b0010;
        tick(); // RUN
        checks++;
        if (lbuf_wen !== 1'b0 || lbuf_waddr !== 12'h333) begin
            errors++; $display("FAIL lbuf_other_unit: wen %0b waddr %h want 0/333", lbuf_wen, lbuf_waddr);
        end
        sub_lbuf_wen = 4'b1010;
        sub_lbuf_ren = 4'b1000;
        #1;
        checks++;
        if (lbuf_wen !== 1'b1 || lbuf_ren !== 1'b1 || lbuf_wdata !== 32'h3333_0003 || lbuf_raddr !== 12'h3A3) begin
            errors++; $display("FAIL lbuf_unit3: wen %0b ren %0b wdata %h raddr %h want 1/1/33330003/3a3", lbuf_wen, lbuf_ren, lbuf_wdata, lbuf_raddr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (hif.spu_busy !== 1'b0 || lbuf_wen !== 1'b0 || lbuf_ren !== 1'b0 || sub_start !== 4'd0 ||
            hif.spu_end !== 1'b0 || sub_cfg !== 96'd0 || hif.spu_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_mid_run: busy %0b wen %0b ren %0b start %b end %0b cfg %h cycles %0d want all 0",
                               hif.spu_busy, lbuf_wen, lbuf_ren, sub_start, hif.spu_end, sub_cfg, hif.spu_cycles);
        end
        rst = 1'b0;
        sub_lbuf_wen = '0;
        sub_lbuf_ren = '0;
    endtask

    initial begin
        rst               = 1'b1;
        sub_end           = '0;
        sub_lbuf_ren      = '0;
        sub_lbuf_wen      = '0;
        sub_lbuf_raddr    = '0;
        sub_lbuf_waddr    = '0;
        sub_lbuf_wdata    = '0;
        hif.spu_config_en = 1'b0;
        hif.spu_op_in     = '0;
        hif.spu_cfg_in    = '0;
        hif.spu_start     = 1'b0;
        hif.spu_err_clr   = 1'b0;
        hif.timeout_limit = '0;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_no_cfg();
        test_same_cycle_and_ovf();
        test_timeout();
        test_bad_op();
        test_lbuf_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
